// File: rtl/ecc_err_monitor_pkg.sv
// rtl/ecc_err_monitor_pkg.sv - shared widths and log record type for the ECC error monitor
// Purpose: address/way widths of the scrubber event stream and the packed log entry.
// Ports: none (package).
package ecc_err_monitor_pkg;

   localparam int unsigned AddrWidth        = 8;
   localparam int unsigned DCACHE_SET_ASSOC = 2;
   // Way index needs at least one bit even for a direct-mapped cache.
   localparam int unsigned WayW = (DCACHE_SET_ASSOC > 1) ? $clog2(DCACHE_SET_ASSOC) : 1;

   typedef struct packed {
      logic                 uncorr;
      logic [WayW-1:0]      way;
      logic [AddrWidth-1:0] add;
   } ecc_err_log_t;

endpackage

// File: rtl/ecc_err_monitor_if.sv
// rtl/ecc_err_monitor_if.sv - event, log stream and status bundle of the ECC error monitor
// Purpose: groups scrubber event inputs, clear, log valid/ready stream and status outputs.
// Ports: slave modport for the monitor, master modport for the driving side.
//   corr_i/uncorr_i/err_add_i/err_way_i : scrubber event pulse and location
//   clear_i                             : clear counters, log, overflow
//   log_valid_o/log_ready_i/log_o       : log head handshake
//   corr_cnt_o/uncorr_cnt_o             : saturating counters
//   overflow_o/irq_o                    : sticky overflow, level interrupt
interface ecc_err_monitor_if #(
   parameter int unsigned CntWidth = 16
) ();
   import ecc_err_monitor_pkg::*;

   logic                 corr_i;
   logic                 uncorr_i;
   logic [AddrWidth-1:0] err_add_i;
   logic [WayW-1:0]      err_way_i;
   logic                 clear_i;
   logic [CntWidth-1:0]  corr_cnt_o;
   logic [CntWidth-1:0]  uncorr_cnt_o;
   logic                 log_valid_o;
   logic                 log_ready_i;
   ecc_err_log_t         log_o;
   logic                 overflow_o;
   logic                 irq_o;

   modport slave (
      input  corr_i, uncorr_i, err_add_i, err_way_i, clear_i, log_ready_i,
      output corr_cnt_o, uncorr_cnt_o, log_valid_o, log_o, overflow_o, irq_o
   );

   modport master (
      output corr_i, uncorr_i, err_add_i, err_way_i, clear_i, log_ready_i,
      input  corr_cnt_o, uncorr_cnt_o, log_valid_o, log_o, overflow_o, irq_o
   );

endinterface

// File: rtl/ecc_err_log_fifo.sv
// rtl/ecc_err_log_fifo.sv - synchronous log FIFO with flush and push-while-full-with-pop
// Purpose: holds event records until the reader drains them.
// Ports:
//   clk_i, rst_ni    : clock, synchronous active-low reset
//   flush_i          : empty the FIFO (wins over push/pop)
//   push_i, data_i   : write request and record
//   pop_i            : remove head (ignored when empty)
//   data_o           : head record (don't-care when empty)
//   full_o, empty_o  : occupancy flags
module ecc_err_log_fifo #(
   parameter int unsigned Depth = 4,
   parameter type         T     = logic
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic flush_i,
   input  logic push_i,
   input  logic pop_i,
   input  T     data_i,
   output T     data_o,
   output logic full_o,
   output logic empty_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam int unsigned CntW = PtrW + 1;

   T                mem_q [Depth];
   T                mem_d [Depth];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            do_push, do_pop;

   assign full_o  = (cnt_q == CntW'(Depth));
   assign empty_o = (cnt_q == '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      do_pop   = pop_i && !empty_o;
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      do_push  = push_i && (!full_o || do_pop);
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/ecc_err_monitor.sv
// rtl/ecc_err_monitor.sv - ECC scrubber event counters, event log and interrupt
// Purpose: counts correctable/uncorrectable events (saturating), logs each event
//   in a FIFO drained over valid/ready, flags log overflow and raises irq_o.
// Ports:
//   clk_i  : clock
//   rst_ni : synchronous active-low reset
//   bus    : ecc_err_monitor_if slave (events, clear, log stream, status)
module ecc_err_monitor #(
   parameter int unsigned CntWidth      = 16,
   parameter int unsigned LogDepth      = 4,
   parameter int unsigned CorrThreshold = 8
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   ecc_err_monitor_if.slave    bus
);
   import ecc_err_monitor_pkg::*;

   logic [CntWidth-1:0] corr_cnt_q, corr_cnt_d;
   logic [CntWidth-1:0] uncorr_cnt_q, uncorr_cnt_d;
   logic                overflow_q, overflow_d;
   logic                irq_q, irq_d;
   logic                evt, pop, push_fifo, pop_fifo, thr_hit;
   logic                fifo_full, fifo_empty;
   ecc_err_log_t        entry, head;

   always_comb begin
      evt   = bus.corr_i | bus.uncorr_i;
      pop   = !fifo_empty && bus.log_ready_i;
      // Uncorrectable takes the record when both pulses arrive together.
      entry = '{uncorr: bus.uncorr_i, way: bus.err_way_i, add: bus.err_add_i};
      // Clear discards same-cycle events and pops.
      push_fifo = evt && !bus.clear_i;
      pop_fifo  = pop && !bus.clear_i;

      corr_cnt_d   = corr_cnt_q;
      uncorr_cnt_d = uncorr_cnt_q;
      overflow_d   = overflow_q;
      if (bus.clear_i) begin
         corr_cnt_d   = '0;
         uncorr_cnt_d = '0;
         overflow_d   = 1'b0;
      end else begin
         if (bus.corr_i && (corr_cnt_q != '1)) begin
            corr_cnt_d = corr_cnt_q + 1'b1;
         end
         if (bus.uncorr_i && (uncorr_cnt_q != '1)) begin
            uncorr_cnt_d = uncorr_cnt_q + 1'b1;
         end
         if (evt && fifo_full && !pop) begin
            overflow_d = 1'b1;
         end
      end

      thr_hit = (CorrThreshold != 0) && (32'(corr_cnt_d) >= CorrThreshold);
      irq_d   = thr_hit || (uncorr_cnt_d != '0) || overflow_d;
   end

   ecc_err_log_fifo #(
      .Depth (LogDepth),
      .T     (ecc_err_log_t)
   ) u_log_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush_i (bus.clear_i),
      .push_i  (push_fifo),
      .pop_i   (pop_fifo),
      .data_i  (entry),
      .data_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
         overflow_q   <= 1'b0;
         irq_q        <= 1'b0;
      end else begin
         corr_cnt_q   <= corr_cnt_d;
         uncorr_cnt_q <= uncorr_cnt_d;
         overflow_q   <= overflow_d;
         irq_q        <= irq_d;
      end
   end

   assign bus.corr_cnt_o   = corr_cnt_q;
   assign bus.uncorr_cnt_o = uncorr_cnt_q;
   assign bus.overflow_o   = overflow_q;
   assign bus.irq_o        = irq_q;
   assign bus.log_valid_o  = !fifo_empty;
   assign bus.log_o        = head;

endmodule

// File: tb/tb_ecc_err_monitor.sv
// tb/tb_ecc_err_monitor.sv - self-checking bench for ecc_err_monitor
module tb_ecc_err_monitor;
   import ecc_err_monitor_pkg::*;

   localparam int unsigned MAXC = 65535;
   localparam int unsigned SMAX = 15;
   localparam int unsigned EW   = $bits(ecc_err_log_t);

   logic clk = 1'b0;
   logic rst_n;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   ecc_err_monitor_if #(.CntWidth(16)) bus ();
   ecc_err_monitor_if #(.CntWidth(4))  sbus ();

   ecc_err_monitor #(.CntWidth(16), .LogDepth(4), .CorrThreshold(8)) u_dut (
      .clk_i (clk), .rst_ni (rst_n), .bus (bus.slave));

   ecc_err_monitor #(.CntWidth(4), .LogDepth(4), .CorrThreshold(8)) u_sat (
      .clk_i (clk), .rst_ni (rst_n), .bus (sbus.slave));

   // Reference model: counts as integers, log as a bounded queue of records.
   int unsigned    m_corr, m_uncorr, s_uncorr;
   bit             m_ovf;
   logic [EW-1:0]  mq[$];

   function automatic logic [EW-1:0] mk(input logic u, input logic [WayW-1:0] w,
                                        input logic [AddrWidth-1:0] a);
      return {u, w, a};
   endfunction

   function automatic bit m_irq();
      return (m_corr >= 8) || (m_uncorr != 0) || m_ovf;
   endfunction

   function automatic void model_step();
      bit popped;
      if (!rst_n) begin
         m_corr = 0; m_uncorr = 0; m_ovf = 0; s_uncorr = 0;
         mq.delete();
         return;
      end
      if (bus.clear_i) begin
         m_corr = 0; m_uncorr = 0; m_ovf = 0;
         mq.delete();
      end else begin
         popped = (mq.size() != 0) && bus.log_ready_i;
         if (bus.corr_i && m_corr < MAXC) m_corr++;
         if (bus.uncorr_i && m_uncorr < MAXC) m_uncorr++;
         if (popped) void'(mq.pop_front());
         if (bus.corr_i || bus.uncorr_i) begin
            if (mq.size() < 4) mq.push_back(mk(bus.uncorr_i, bus.err_way_i, bus.err_add_i));
            else m_ovf = 1;
         end
      end
      if (sbus.clear_i) s_uncorr = 0;
      else if (sbus.uncorr_i && s_uncorr < SMAX) s_uncorr++;
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      bus.corr_i = 0; bus.uncorr_i = 0; bus.clear_i = 0; bus.log_ready_i = 0;
      bus.err_add_i = '0; bus.err_way_i = '0;
      sbus.corr_i = 0; sbus.uncorr_i = 0; sbus.clear_i = 0; sbus.log_ready_i = 0;
      sbus.err_add_i = '0; sbus.err_way_i = '0;
   endtask

   task automatic do_clear();
      bus.clear_i = 1; tick(); bus.clear_i = 0;
   endtask

   task automatic event_cycle(input logic c, input logic u, input logic [7:0] a, input logic w);
      bus.corr_i = c; bus.uncorr_i = u; bus.err_add_i = a; bus.err_way_i = w;
      tick();
      bus.corr_i = 0; bus.uncorr_i = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 0; tick(); tick(); rst_n = 1;
      for (int i = 0; i < 20; i++) begin
         total++;
         if ({bus.corr_cnt_o, bus.uncorr_cnt_o, bus.log_valid_o, bus.overflow_o, bus.irq_o} !== '0) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got corr=%0d uncorr=%0d valid=%0b ovf=%0b irq=%0b exp all 0",
                     i, bus.corr_cnt_o, bus.uncorr_cnt_o, bus.log_valid_o, bus.overflow_o, bus.irq_o);
         end
         tick();
      end
      total++;
      if (sbus.uncorr_cnt_o !== 4'd0 || sbus.irq_o !== 1'b0) begin
         bad++; $display("FAIL reset_sat got uncorr=%0d irq=%0b exp 0 0", sbus.uncorr_cnt_o, sbus.irq_o);
      end
   endtask

   task automatic test_single();
      logic [EW-1:0] h;
      event_cycle(1, 0, 8'h2A, 1'b1);
      h = bus.log_o;
      total++;
      if (bus.corr_cnt_o !== 16'd1) begin
         bad++; $display("FAIL single_cnt got=%0d exp=1", bus.corr_cnt_o);
      end
      total++;
      if (bus.log_valid_o !== 1'b1 || h !== mk(0, 1'b1, 8'h2A)) begin
         bad++; $display("FAIL single_log got valid=%0b entry=%0h exp valid=1 entry=%0h",
                         bus.log_valid_o, h, mk(0, 1'b1, 8'h2A));
      end
      bus.log_ready_i = 1; tick(); bus.log_ready_i = 0;
      total++;
      if (bus.log_valid_o !== 1'b0) begin
         bad++; $display("FAIL single_pop got valid=%0b exp=0", bus.log_valid_o);
      end
   endtask

   task automatic test_threshold();
      do_clear();
      bus.log_ready_i = 1;
      for (int i = 0; i < 8; i++) begin
         event_cycle(1, 0, 8'(i), 1'b0);
         total++;
         if (bus.irq_o !== (i == 7)) begin
            bad++; $display("FAIL thr_irq pulse=%0d got=%0b exp=%0b", i + 1, bus.irq_o, i == 7);
         end
      end
      bus.log_ready_i = 0;
      do_clear();
      total++;
      if (bus.irq_o !== 1'b0 || bus.corr_cnt_o !== 16'd0) begin
         bad++; $display("FAIL thr_clear got irq=%0b cnt=%0d exp 0 0", bus.irq_o, bus.corr_cnt_o);
      end
   endtask

   task automatic test_overflow();
      logic [EW-1:0] h;
      do_clear();
      for (int i = 0; i < 5; i++) event_cycle(1, 0, 8'(8'h10 + i), 1'(i));
      total++;
      if (bus.overflow_o !== 1'b1 || bus.irq_o !== 1'b1 || bus.corr_cnt_o !== 16'd5) begin
         bad++; $display("FAIL ovf_flags got ovf=%0b irq=%0b cnt=%0d exp 1 1 5",
                         bus.overflow_o, bus.irq_o, bus.corr_cnt_o);
      end
      for (int i = 0; i < 4; i++) begin
         h = bus.log_o;
         total++;
         if (bus.log_valid_o !== 1'b1 || h !== mk(0, 1'(i), 8'(8'h10 + i))) begin
            bad++; $display("FAIL ovf_order idx=%0d got valid=%0b entry=%0h exp entry=%0h",
                            i, bus.log_valid_o, h, mk(0, 1'(i), 8'(8'h10 + i)));
         end
         bus.log_ready_i = 1; tick(); bus.log_ready_i = 0;
      end
      total++;
      if (bus.log_valid_o !== 1'b0 || bus.overflow_o !== 1'b1) begin
         bad++; $display("FAIL ovf_drained got valid=%0b ovf=%0b exp 0 1", bus.log_valid_o, bus.overflow_o);
      end
   endtask

   task automatic test_full_pushpop();
      logic [EW-1:0] h;
      int n;
      do_clear();
      for (int i = 0; i < 4; i++) event_cycle(1, 0, 8'(8'h40 + i), 1'b0);
      bus.log_ready_i = 1;
      event_cycle(1, 0, 8'h55, 1'b1);
      total++;
      if (bus.overflow_o !== 1'b0 || bus.log_valid_o !== 1'b1) begin
         bad++; $display("FAIL full_pp_ovf got ovf=%0b valid=%0b exp 0 1", bus.overflow_o, bus.log_valid_o);
      end
      n = 0;
      for (int k = 0; k < 8 && bus.log_valid_o === 1'b1; k++) begin
         h = bus.log_o;
         total++;
         if (mq.size() == 0 || h !== mq[0]) begin
            bad++; $display("FAIL full_pp_entry idx=%0d got=%0h exp=%0h", n, h, (mq.size() != 0) ? mq[0] : '0);
         end
         n++;
         tick();
      end
      bus.log_ready_i = 0;
      total++;
      if (n != 4) begin
         bad++; $display("FAIL full_pp_occ got=%0d exp=4", n);
      end
      do_clear();
      event_cycle(1, 1, 8'h77, 1'b1);
      h = bus.log_o;
      total++;
      if (bus.corr_cnt_o !== 16'd1 || bus.uncorr_cnt_o !== 16'd1 || h !== mk(1, 1'b1, 8'h77)) begin
         bad++; $display("FAIL both_pulse got corr=%0d uncorr=%0d entry=%0h exp 1 1 %0h",
                         bus.corr_cnt_o, bus.uncorr_cnt_o, h, mk(1, 1'b1, 8'h77));
      end
      bus.log_ready_i = 1; tick(); bus.log_ready_i = 0;
      total++;
      if (bus.log_valid_o !== 1'b0) begin
         bad++; $display("FAIL both_one_entry got valid=%0b exp=0", bus.log_valid_o);
      end
   endtask

   task automatic test_saturation();
      sbus.clear_i = 1; tick(); sbus.clear_i = 0;
      for (int i = 0; i < 20; i++) begin
         sbus.uncorr_i = 1; tick(); sbus.uncorr_i = 0;
         total++;
         if (sbus.uncorr_cnt_o !== 4'(s_uncorr) || s_uncorr != ((i + 1 < 15) ? i + 1 : 15)) begin
            bad++; $display("FAIL sat_cnt pulse=%0d got=%0d exp=%0d", i + 1, sbus.uncorr_cnt_o,
                            (i + 1 < 15) ? i + 1 : 15);
         end
      end
   endtask

   task automatic test_reset_mid();
      do_clear();
      for (int i = 0; i < 3; i++) event_cycle(0, 1, 8'(i), 1'b0);
      total++;
      if (bus.log_valid_o !== 1'b1 || bus.uncorr_cnt_o !== 16'd3) begin
         bad++; $display("FAIL rstmid_pre got valid=%0b uncorr=%0d exp 1 3", bus.log_valid_o, bus.uncorr_cnt_o);
      end
      rst_n = 0; tick(); rst_n = 1;
      total++;
      if (bus.log_valid_o !== 1'b0 || bus.uncorr_cnt_o !== 16'd0 || bus.irq_o !== 1'b0) begin
         bad++; $display("FAIL rstmid_post got valid=%0b uncorr=%0d irq=%0b exp 0 0 0",
                         bus.log_valid_o, bus.uncorr_cnt_o, bus.irq_o);
      end
   endtask

   task automatic test_random();
      logic [EW-1:0] h;
      do_clear();
      for (int i = 0; i < 400; i++) begin
         bus.corr_i      = ($urandom_range(0, 2) == 0);
         bus.uncorr_i    = ($urandom_range(0, 6) == 0);
         bus.log_ready_i = ($urandom_range(0, 2) == 0);
         bus.clear_i     = ($urandom_range(0, 60) == 0);
         bus.err_add_i   = 8'($urandom);
         bus.err_way_i   = 1'($urandom);
         tick();
         h = bus.log_o;
         total++;
         if (bus.corr_cnt_o !== 16'(m_corr) || bus.uncorr_cnt_o !== 16'(m_uncorr) ||
             bus.overflow_o !== m_ovf || bus.irq_o !== m_irq() ||
             bus.log_valid_o !== (mq.size() != 0) || (mq.size() != 0 && h !== mq[0])) begin
            bad++;
            $display("FAIL rand cyc=%0d got c=%0d u=%0d ovf=%0b irq=%0b v=%0b e=%0h exp c=%0d u=%0d ovf=%0b irq=%0b v=%0b e=%0h",
                     i, bus.corr_cnt_o, bus.uncorr_cnt_o, bus.overflow_o, bus.irq_o, bus.log_valid_o, h,
                     m_corr, m_uncorr, m_ovf, m_irq(), mq.size() != 0, (mq.size() != 0) ? mq[0] : '0);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 0;
      test_reset();
      test_single();
      test_threshold();
      test_overflow();
      test_full_pushpop();
      test_saturation();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
